// File: rtl/mem_load_sequencer_pkg.sv
// rtl/mem_load_sequencer_pkg.sv - shared encodings and state type for the load sequencer
package mem_load_sequencer_pkg;

  localparam int ADDR_W_DEF = 8;

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_MEM_WRITE  = 2'd1;
  localparam logic [1:0] ST_PROCESSING = 2'd2;
  localparam logic [1:0] ST_MEM_READ   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_DATA,
    S_LOAD_INSTR,
    S_RUN,
    S_DONE,
    S_ERR
  } seq_state_t;

  // Per-core status line; disabled cores always report idle.
  function automatic logic [1:0] core_status(input seq_state_t s, input logic en);
    logic [1:0] v;
    case (s)
      S_LOAD_DATA, S_LOAD_INSTR: v = ST_MEM_WRITE;
      S_RUN:                     v = ST_PROCESSING;
      S_DONE:                    v = ST_MEM_READ;
      default:                   v = ST_IDLE;
    endcase
    return en ? v : ST_IDLE;
  endfunction

endpackage

// File: rtl/mem_load_sequencer_seg_writer.sv
// rtl/mem_load_sequencer_seg_writer.sv - one memory file-write port: counter, address/word/strobe registers, overflow detect
module seg_writer #(
  parameter int W      = 16,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              accept,
  input  logic              last,
  input  logic [W-1:0]      wdata,
  output logic              wr_en,
  output logic [ADDR_W-1:0] addr,
  output logic [W-1:0]      data,
  output logic              overflow
);

  logic [ADDR_W-1:0] count;
  logic              at_limit;

  assign at_limit = (count == ADDR_W'(DEPTH - 1));
  assign overflow = accept & ~last & at_limit;

  // The counter saturates at the last slot so it can never wrap back to 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      wr_en <= 1'b0;
      addr  <= '0;
      data  <= '0;
    end else begin
      wr_en <= accept;
      if (clear) begin
        count <= '0;
      end else if (accept && !at_limit) begin
        count <= count + 1'b1;
      end
      if (accept) begin
        addr <= count;
        data <= wdata;
      end
    end
  end

endmodule

// File: rtl/mem_load_sequencer.sv
// rtl/mem_load_sequencer.sv - loads data and instruction segments, runs the cores, waits for completion
module mem_load_sequencer
  import mem_load_sequencer_pkg::*;
#(
  parameter int         ADDR_W      = ADDR_W_DEF,
  parameter int         DATA_DEPTH  = 256,
  parameter int         INSTR_DEPTH = 256,
  parameter logic [3:0] CORE_EN     = 4'b1111,
  parameter int         TIMEOUT     = 65535
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [15:0]       in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              data_wr_en_file,
  output logic [ADDR_W-1:0] data_addr_file,
  output logic [15:0]       data_file,
  output logic              instr_wr_en_file,
  output logic [ADDR_W-1:0] instr_addr_file,
  output logic [7:0]        instr_file,
  output logic [1:0]        status0,
  output logic [1:0]        status1,
  output logic [1:0]        status2,
  output logic [1:0]        status3,
  input  logic [3:0]        end_process,
  output logic              busy,
  output logic              done,
  output logic              error
);

  seq_state_t  state, state_n;
  logic        clear, accept, data_ovf, instr_ovf;
  logic [3:0]  sticky;
  logic [15:0] run_cnt;

  assign in_ready = (state == S_LOAD_DATA) || (state == S_LOAD_INSTR);
  assign accept   = in_valid & in_ready;
  assign busy     = in_ready || (state == S_RUN);
  assign done     = (state == S_DONE);
  assign error    = (state == S_ERR);
  assign status0  = core_status(state, CORE_EN[0]);
  assign status1  = core_status(state, CORE_EN[1]);
  assign status2  = core_status(state, CORE_EN[2]);
  assign status3  = core_status(state, CORE_EN[3]);

  seg_writer #(.W(16), .ADDR_W(ADDR_W), .DEPTH(DATA_DEPTH)) u_data_writer (
    .clk(clk), .reset(reset), .clear(clear),
    .accept(accept && state == S_LOAD_DATA), .last(in_last), .wdata(in_data),
    .wr_en(data_wr_en_file), .addr(data_addr_file), .data(data_file), .overflow(data_ovf)
  );

  seg_writer #(.W(8), .ADDR_W(ADDR_W), .DEPTH(INSTR_DEPTH)) u_instr_writer (
    .clk(clk), .reset(reset), .clear(clear),
    .accept(accept && state == S_LOAD_INSTR), .last(in_last), .wdata(in_data[7:0]),
    .wr_en(instr_wr_en_file), .addr(instr_addr_file), .data(instr_file), .overflow(instr_ovf)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      sticky  <= '0;
      run_cnt <= '0;
    end else begin
      state <= state_n;
      if (clear) begin
        sticky <= '0;
      end else if (state == S_RUN) begin
        sticky <= sticky | end_process;
      end
      run_cnt <= (state == S_RUN) ? run_cnt + 1'b1 : '0;
    end
  end

  always_comb begin
    state_n = state;
    clear   = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_n = S_LOAD_DATA;
          clear   = 1'b1;
        end
      end
      S_LOAD_DATA: begin
        if (accept && in_last) state_n = S_LOAD_INSTR;
        else if (data_ovf)     state_n = S_ERR;
      end
      S_LOAD_INSTR: begin
        if (accept && in_last) state_n = S_RUN;
        else if (instr_ovf)    state_n = S_ERR;
      end
      S_RUN: begin
        // run_cnt reaches TIMEOUT on the same edge that enters ERR.
        if (((sticky | end_process) & CORE_EN) == CORE_EN) state_n = S_DONE;
        else if (run_cnt == 16'(TIMEOUT - 1))              state_n = S_ERR;
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule
